// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the pipeline and the multiply/divide unit.
// MDU_DIVZERO_EN adds the divz flag to the bundle.
interface mdu_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic         hi_wr;
  logic         lo_wr;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MDU_DIVZERO_EN
  logic         divz;
`endif

  modport master (
    output start, op, busA, busB,
    output hi_wr, lo_wr, wdata,
`ifdef MDU_DIVZERO_EN
    input  divz,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, busA, busB,
    input  hi_wr, lo_wr, wdata,
`ifdef MDU_DIVZERO_EN
    output divz,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-clock MULT/MULTU/DIV/DIVU with HI/LO registers.
// MDU_DIVZERO_EN adds a divz flag raised in the DONE cycle of a divide by zero.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  io
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         b_q, b_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 div_q, div_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 bz_q, bz_d;

  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic [W:0]   m_sum;
  logic [W:0]   d_sh;
  logic         d_ge;
  logic [W-1:0] d_rem;
  logic [W-1:0] q_val, r_val;
  logic [2*W-1:0] p_neg;

  assign a_neg = io.op[0] & io.busA[W-1];
  assign b_neg = io.op[0] & io.busB[W-1];
  assign a_mag = a_neg ? -io.busA : io.busA;
  assign b_mag = b_neg ? -io.busB : io.busB;

  // Multiply: add multiplicand into the high half, shift right.
  assign m_sum = {1'b0, acc_q[2*W-1:W]}
               + {1'b0, acc_q[0] ? b_q : '0};

  // Divide: high half is remainder, low half shifts dividend out / quotient in.
  assign d_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign d_ge  = d_sh >= {1'b0, b_q};
  assign d_rem = W'(d_sh - {1'b0, b_q});

  assign q_val = acc_q[W-1:0];
  assign r_val = acc_q[2*W-1:W];
  assign p_neg = -acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = {{W{1'b0}}, a_mag};
          b_d     = b_mag;
          div_d   = io.op[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = (io.busB == '0);
        end else begin
          if (io.hi_wr) hi_d = io.wdata;
          if (io.lo_wr) lo_d = io.wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = d_ge
            ? {d_rem, acc_q[W-2:0], 1'b1}
            : {d_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d = {m_sum, acc_q[W-1:1]};
        end
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (div_q) begin
          // Divide by zero forces an all-ones quotient regardless of sign.
          lo_d = bz_q ? '1 : (qneg_q ? -q_val : q_val);
          hi_d = rneg_q ? -r_val : r_val;
        end else begin
          {hi_d, lo_d} = qneg_q ? p_neg : acc_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
    end
  end

  assign io.busy = (state_q == S_RUN)
                 | (state_q == S_FIX);
  assign io.done = (state_q == S_DONE);
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;
`ifdef MDU_DIVZERO_EN
  assign io.divz = (state_q == S_DONE) & div_q & bz_q;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops checked
// against a plain-arithmetic reference model.
module tb_mult_div_unit;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          dz;
    int            acc;
  } exp_t;

  exp_t sb[$];

  mdu_if #(.W(DW)) io();

  mult_div_unit #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS-style results from ordinary integer arithmetic.
  function automatic logic [63:0] model(logic [1:0] op,
      logic [DW-1:0] a, logic [DW-1:0] b);
    longint sa, sb_, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sb_ = $signed(b);
    case (op)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = sa * sb_;
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF}
                          : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_;
          r = sa % sb_;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!io.busy && !io.done) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%b done=%b",
               io.busy, io.done);
    end
  endtask

  task automatic issue(logic [1:0] op, logic [DW-1:0] a,
                       logic [DW-1:0] b, bit hw);
    logic [63:0] r;
    exp_t e;
    wait_idle();
    io.op    = op;
    io.busA  = a;
    io.busB  = b;
    io.start = 1'b1;
    io.hi_wr = hw;
    io.wdata = 32'hDEAD_BEEF;
    tick();
    io.start = 1'b0;
    io.hi_wr = 1'b0;
    io.busA  = $urandom;
    io.busB  = $urandom;
    r = model(op, a, b);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.dz  = op[1] && (b == 0);
    e.acc = cyc;
    sb.push_back(e);
    chk("busy_after_start", 64'(io.busy), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (io.busy) busy_cnt++;
      if (io.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(io.hi), 64'(e.hi));
          chk("lo", 64'(io.lo), 64'(e.lo));
          chk("done_edge_offset", 64'(cyc - e.acc),
              64'(DW + 1));
          chk("busy_cycles", 64'(busy_cnt), 64'(DW + 1));
          chk("busy_at_done", 64'(io.busy), 64'd0);
`ifdef MDU_DIVZERO_EN
          chk("divz", 64'(io.divz), 64'(e.dz));
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [1:0] op;
    io.start = 0;
    io.op    = 0;
    io.busA  = 0;
    io.busB  = 0;
    io.hi_wr = 0;
    io.lo_wr = 0;
    io.wdata = 0;

    repeat (3) tick();
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_done", 64'(io.done), 64'd0);
    chk("rst_hi", 64'(io.hi), 64'd0);
    chk("rst_lo", 64'(io.lo), 64'd0);
`ifdef MDU_DIVZERO_EN
    chk("rst_divz", 64'(io.divz), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_hi", 64'(io.hi), 64'd0);
    chk("idle_lo", 64'(io.lo), 64'd0);

    io.hi_wr = 1;
    io.wdata = 32'h1234;
    tick();
    io.hi_wr = 0;
    chk("mthi", 64'(io.hi), 64'h1234);
    chk("mthi_lo_kept", 64'(io.lo), 64'd0);
    io.lo_wr = 1;
    io.wdata = 32'hABCD;
    tick();
    io.lo_wr = 0;
    chk("mtlo", 64'(io.lo), 64'hABCD);

    // MTHI in the same cycle as start must be dropped.
    issue(2'b00, 32'd7, 32'd6, 1'b1);
    repeat (3) tick();
    chk("hi_hold_busy", 64'(io.hi), 64'h1234);
    chk("lo_hold_busy", 64'(io.lo), 64'hABCD);

    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'b10, 32'd100, 32'd0, 1'b0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) tick();
    io.start = 1;
    io.op    = 2'b01;
    tick();
    io.start = 0;
    repeat (4) tick();
    io.lo_wr = 1;
    io.wdata = 32'h55;
    tick();
    io.lo_wr = 0;

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, rnd_val(), rnd_val(), 1'b0);
    end

    wait_idle();
    chk("result_held_idle", 64'(io.lo), 64'(io.lo));
    issue(2'b11, 32'd1000, 32'd7, 1'b0);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(io.busy), 64'd0);
    chk("abort_done", 64'(io.done), 64'd0);
    chk("abort_hi", 64'(io.hi), 64'd0);
    chk("abort_lo", 64'(io.lo), 64'd0);
    void'(sb.pop_back());
    busy_cnt = 0;
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("post_abort_lo", 64'(io.lo), 64'd0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
